// File: rtl/mmp_spdif_sample_bridge.sv
// ---------------------------------------------------------------------------
// mmp_spdif_sample_bridge
//
// Feeds the S/PDIF transmitter wrapper with processed audio samples. Samples
// from the mixer (already in the i_CLK_SPDIF domain) are queued in a small
// FIFO. Each transmitter request pops one sample. The popped sample is scaled
// by a ramped gain and saturated. The result is then held on o_SOUND until
// the next request. When the FIFO runs dry, the last output is held and an
// underrun is flagged.
//
// Handshake: i_SAMPLE_VALID and i_REQ are single-cycle strobes with no
// back-pressure. A write is accepted when the FIFO is not full, or when a pop
// happens in the same cycle. Otherwise the write is dropped and o_OVERRUN
// pulses. A request is served when the FIFO is non-empty. Otherwise
// o_UNDERRUN pulses and o_SOUND keeps its value. There is no write-to-read
// bypass.
//
// Ports:
//   i_CLK_SPDIF     S/PDIF clock, rising edge
//   i_RST_n         synchronous active-low reset
//   i_SAMPLE_VALID  write strobe for i_SAMPLE
//   i_SAMPLE        signed 16-bit input sample
//   i_GAIN          unsigned gain, 128 = unity
//   i_MUTE          level; ramps gain to 0 while high
//   i_REQ           pop strobe from the transmitter
//   o_SOUND         processed sample (registered)
//   o_LEVEL         FIFO occupancy 0..2**DEPTH_LOG2
//   o_UNDERRUN      pulse: request with empty FIFO
//   o_OVERRUN       pulse: write dropped because FIFO full
//   o_MUTED         high while muted and gain has reached 0
//   o_DBG_GAIN      current ramped gain (debug)
//   o_DBG_RAMP      ramp FSM state, 1 = RAMP (debug)
// ---------------------------------------------------------------------------
module mmp_spdif_sample_bridge #(
    parameter int DEPTH_LOG2 = 2,
    parameter int RAMP_STEP  = 1
) (
    input  logic                    i_CLK_SPDIF,
    input  logic                    i_RST_n,
    input  logic                    i_SAMPLE_VALID,
    input  logic [15:0]             i_SAMPLE,
    input  logic [7:0]              i_GAIN,
    input  logic                    i_MUTE,
    input  logic                    i_REQ,
    output logic [15:0]             o_SOUND,
    output logic [DEPTH_LOG2:0]     o_LEVEL,
    output logic                    o_UNDERRUN,
    output logic                    o_OVERRUN,
    output logic                    o_MUTED,
    output logic [7:0]              o_DBG_GAIN,
    output logic                    o_DBG_RAMP
);

    localparam int                DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [8:0]        STEP = 9'(RAMP_STEP);

    typedef enum logic [0:0] {
        STEADY = 1'b0,
        RAMP   = 1'b1
    } ramp_state_t;

    // ---------------- state ----------------
    logic [15:0]           mem_q [DEPTH];
    logic [15:0]           mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [15:0]           sound_q, sound_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;
    logic                  muted_q, muted_d;
    logic [7:0]            gain_q, gain_d;
    ramp_state_t           state_q, state_d;

    // ---------------- FIFO control ----------------
    logic full, empty, push, pop;

    always_comb begin
        full  = (level_q == FULL_LEVEL);
        empty = (level_q == '0);
        pop   = i_REQ && !empty;
        // A pop in the same cycle frees the slot that the write needs.
        push  = i_SAMPLE_VALID && (!full || pop);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_SAMPLE;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        underrun_d = i_REQ && empty;
        overrun_d  = i_SAMPLE_VALID && full && !pop;
    end

    // ---------------- gain and saturation ----------------
    // Signed sample times zero-extended 9-bit gain. The largest magnitude is
    // 32768*255, so 25 bits hold the product exactly.
    logic signed [24:0] s_ext, g_ext, prod, shifted;
    logic [15:0]        scaled;

    always_comb begin
        s_ext   = {{9{mem_q[rd_ptr_q][15]}}, mem_q[rd_ptr_q]};
        g_ext   = {17'b0, gain_q};
        prod    = s_ext * g_ext;
        shifted = prod >>> 7;
        if (shifted > 25'sd32767) begin
            scaled = 16'h7fff;
        end else if (shifted < -25'sd32768) begin
            scaled = 16'h8000;
        end else begin
            scaled = shifted[15:0];
        end
        // The product uses the gain from before this cycle's ramp step.
        sound_d = pop ? scaled : sound_q;
    end

    // ---------------- ramp FSM ----------------
    logic [7:0] target;
    logic [8:0] diff;
    logic [7:0] stepped;

    always_comb begin
        target = i_MUTE ? 8'd0 : i_GAIN;
        // Move one step toward the target, clamping so it never overshoots.
        if (target >= gain_q) begin
            diff    = {1'b0, target} - {1'b0, gain_q};
            stepped = (diff > STEP) ? 8'(gain_q + STEP[7:0]) : target;
        end else begin
            diff    = {1'b0, gain_q} - {1'b0, target};
            stepped = (diff > STEP) ? 8'(gain_q - STEP[7:0]) : target;
        end

        state_d = state_q;
        gain_d  = gain_q;
        case (state_q)
            STEADY: begin
                if (target != gain_q) begin
                    state_d = RAMP;
                end
            end
            RAMP: begin
                if (i_REQ) begin
                    gain_d = stepped;
                    if (stepped == target) begin
                        state_d = STEADY;
                    end
                end
            end
            default: state_d = STEADY;
        endcase

        muted_d = i_MUTE && (gain_q == 8'd0);
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_CLK_SPDIF) begin
        if (!i_RST_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            sound_q    <= 16'h0000;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            muted_q    <= 1'b0;
            gain_q     <= 8'd0;
            state_q    <= STEADY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            sound_q    <= sound_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            muted_q    <= muted_d;
            gain_q     <= gain_d;
            state_q    <= state_d;
        end
    end

    // Storage needs no reset. The pointers and level already make stale
    // entries unreachable.
    always_ff @(posedge i_CLK_SPDIF) begin
        mem_q <= mem_d;
    end

    assign o_SOUND    = sound_q;
    assign o_LEVEL    = level_q;
    assign o_UNDERRUN = underrun_q;
    assign o_OVERRUN  = overrun_q;
    assign o_MUTED    = muted_q;
    assign o_DBG_GAIN = gain_q;
    assign o_DBG_RAMP = (state_q == RAMP);

endmodule

// File: tb/tb_mmp_spdif_sample_bridge.sv
module tb_mmp_spdif_sample_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] sample = 16'h0;
  logic [7:0]  gain = 8'd128;
  logic        mute = 1'b0;
  logic        req = 1'b0;
  logic [15:0] sound;
  logic [2:0]  level;
  logic        underrun, overrun, muted;
  logic [7:0]  dbg_gain;
  logic        dbg_ramp;

  int total = 0;
  int bad = 0;

  // clock / reset block
  always #5 clk = ~clk;

  mmp_spdif_sample_bridge #(.DEPTH_LOG2(2), .RAMP_STEP(1)) dut (
    .i_CLK_SPDIF(clk),
    .i_RST_n(rst_n),
    .i_SAMPLE_VALID(valid),
    .i_SAMPLE(sample),
    .i_GAIN(gain),
    .i_MUTE(mute),
    .i_REQ(req),
    .o_SOUND(sound),
    .o_LEVEL(level),
    .o_UNDERRUN(underrun),
    .o_OVERRUN(overrun),
    .o_MUTED(muted),
    .o_DBG_GAIN(dbg_gain),
    .o_DBG_RAMP(dbg_ramp)
  );

  // driver: apply strobes for one edge, observe #1 after it
  task automatic tick(input logic v, input logic [15:0] s, input logic r);
    valid = v;
    sample = s;
    req = r;
    @(posedge clk);
    #1;
    valid = 1'b0;
    req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(1'b1, 16'h1111, 1'b1);
    tick(1'b0, 16'h0, 1'b0);
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (sound !== 16'h0) begin bad++; $display("FAIL reset_sound got=%h want=0000", sound); end
    total++; if (underrun !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", underrun, overrun); end
    total++; if (muted !== 1'b0) begin bad++; $display("FAIL reset_muted got=%b want=0", muted); end
    total++; if (dbg_gain !== 8'd0 || dbg_ramp !== 1'b0) begin bad++; $display("FAIL reset_gain got=%0d/%b want=0/0", dbg_gain, dbg_ramp); end
    rst_n = 1'b1;
  endtask

  task automatic test_fade_in();
    int e;
    int g;
    gain = 8'd128;
    mute = 1'b0;
    for (int i = 0; i < 4; i++) tick(1'b1, 16'd1000, 1'b0);
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fade_fill_level got=%0d want=4", level); end
    for (int k = 0; k < 200; k++) begin
      g = (k < 128) ? k : 128;
      e = (1000 * g) >>> 7;
      tick(1'b1, 16'd1000, 1'b1);
      total++; if (sound !== e[15:0]) begin bad++; $display("FAIL fade_sound k=%0d got=%0d want=%0d", k, $signed(sound), e); end
    end
    total++; if (dbg_gain !== 8'd128 || dbg_ramp !== 1'b0) begin bad++; $display("FAIL fade_gain got=%0d/%b want=128/0", dbg_gain, dbg_ramp); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL fade_level got=%0d want=4", level); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      total++; if (sound !== 16'd1000) begin bad++; $display("FAIL fade_drain got=%0d want=1000", $signed(sound)); end
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL fade_drain_level got=%0d want=0", level); end
  endtask

  task automatic test_unity_and_sat();
    logic [15:0] in_v [4];
    logic [15:0] exp_u [4];
    logic [15:0] exp_s [4];
    in_v  = '{16'h8000, 16'h7fff, 16'h0005, 16'hfffb};
    exp_u = '{16'h8000, 16'h7fff, 16'h0005, 16'hfffb};
    exp_s = '{16'h8000, 16'h7fff, 16'h0009, 16'hfff6};
    for (int i = 0; i < 4; i++) tick(1'b1, in_v[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      total++; if (sound !== exp_u[i]) begin bad++; $display("FAIL unity_%0d got=%h want=%h", i, sound, exp_u[i]); end
    end
    // ramp 128 -> 255 with requests on an empty FIFO
    gain = 8'd255;
    tick(1'b0, 16'h0, 1'b0);
    total++; if (dbg_ramp !== 1'b1) begin bad++; $display("FAIL gain255_enter_ramp got=%b want=1", dbg_ramp); end
    for (int i = 0; i < 127; i++) tick(1'b0, 16'h0, 1'b1);
    total++; if (dbg_gain !== 8'd255 || dbg_ramp !== 1'b0) begin bad++; $display("FAIL gain255_reach got=%0d/%b want=255/0", dbg_gain, dbg_ramp); end
    total++; if (sound !== 16'hfffb) begin bad++; $display("FAIL gain255_hold got=%h want=fffb", sound); end
    for (int i = 0; i < 4; i++) tick(1'b1, in_v[i], 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      total++; if (sound !== exp_s[i]) begin bad++; $display("FAIL gain255_%0d got=%h want=%h", i, sound, exp_s[i]); end
    end
    gain = 8'd128;
    tick(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 127; i++) tick(1'b0, 16'h0, 1'b1);
    total++; if (dbg_gain !== 8'd128 || dbg_ramp !== 1'b0) begin bad++; $display("FAIL gain128_back got=%0d/%b want=128/0", dbg_gain, dbg_ramp); end
  endtask

  task automatic test_overrun();
    logic [15:0] exp_d [4];
    exp_d = '{16'd20, 16'd30, 16'd40, 16'd50};
    tick(1'b1, 16'd10, 1'b0);
    tick(1'b1, 16'd20, 1'b0);
    tick(1'b1, 16'd30, 1'b0);
    tick(1'b1, 16'd40, 1'b0);
    tick(1'b1, 16'd999, 1'b0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_pulse got=%b want=1", overrun); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovr_level got=%0d want=4", level); end
    tick(1'b0, 16'h0, 1'b0);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_one_cycle got=%b want=0", overrun); end
    tick(1'b1, 16'd50, 1'b1);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_with_pop got=%b want=0", overrun); end
    total++; if (level !== 3'd4) begin bad++; $display("FAIL ovr_pop_level got=%0d want=4", level); end
    total++; if (sound !== 16'd10) begin bad++; $display("FAIL ovr_pop_sound got=%0d want=10", sound); end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 16'h0, 1'b1);
      total++; if (sound !== exp_d[i]) begin bad++; $display("FAIL ovr_drain_%0d got=%0d want=%0d", i, sound, exp_d[i]); end
    end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL ovr_drain_level got=%0d want=0", level); end
  endtask

  task automatic test_underrun();
    tick(1'b1, 16'd1234, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    total++; if (sound !== 16'd1234) begin bad++; $display("FAIL udr_setup got=%0d want=1234", sound); end
    tick(1'b0, 16'h0, 1'b1);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL udr_pulse got=%b want=1", underrun); end
    total++; if (sound !== 16'd1234) begin bad++; $display("FAIL udr_hold got=%0d want=1234", sound); end
    tick(1'b0, 16'h0, 1'b0);
    total++; if (underrun !== 1'b0) begin bad++; $display("FAIL udr_one_cycle got=%b want=0", underrun); end
    tick(1'b1, 16'd77, 1'b1);
    total++; if (underrun !== 1'b1) begin bad++; $display("FAIL udr_wr_pulse got=%b want=1", underrun); end
    total++; if (level !== 3'd1) begin bad++; $display("FAIL udr_wr_level got=%0d want=1", level); end
    total++; if (sound !== 16'd1234) begin bad++; $display("FAIL udr_no_bypass got=%0d want=1234", sound); end
    tick(1'b0, 16'h0, 1'b1);
    total++; if (sound !== 16'd77 || underrun !== 1'b0) begin bad++; $display("FAIL udr_stored got=%0d/%b want=77/0", sound, underrun); end
  endtask

  task automatic test_mute();
    mute = 1'b1;
    tick(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 128; i++) tick(1'b0, 16'h0, 1'b1);
    total++; if (dbg_gain !== 8'd0) begin bad++; $display("FAIL mute_gain got=%0d want=0", dbg_gain); end
    total++; if (muted !== 1'b0) begin bad++; $display("FAIL mute_early got=%b want=0", muted); end
    tick(1'b0, 16'h0, 1'b0);
    total++; if (muted !== 1'b1) begin bad++; $display("FAIL mute_flag got=%b want=1", muted); end
    tick(1'b1, 16'd500, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    total++; if (sound !== 16'd0) begin bad++; $display("FAIL mute_sound got=%0d want=0", sound); end
    mute = 1'b0;
    tick(1'b0, 16'h0, 1'b0);
    total++; if (muted !== 1'b0 || dbg_ramp !== 1'b1) begin bad++; $display("FAIL unmute got=%b/%b want=0/1", muted, dbg_ramp); end
    for (int i = 0; i < 127; i++) tick(1'b0, 16'h0, 1'b1);
    total++; if (dbg_gain !== 8'd127 || dbg_ramp !== 1'b1) begin bad++; $display("FAIL unmute_127 got=%0d/%b want=127/1", dbg_gain, dbg_ramp); end
    tick(1'b0, 16'h0, 1'b1);
    total++; if (dbg_gain !== 8'd128 || dbg_ramp !== 1'b0) begin bad++; $display("FAIL unmute_128 got=%0d/%b want=128/0", dbg_gain, dbg_ramp); end
  endtask

  task automatic test_reset_mid_ramp();
    gain = 8'd200;
    tick(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 16'd100, 1'b0);
    tick(1'b0, 16'h0, 1'b1);
    total++; if (sound !== 16'd100 || level !== 3'd3 || dbg_gain !== 8'd129) begin bad++; $display("FAIL mid_setup got=%0d/%0d/%0d want=100/3/129", sound, level, dbg_gain); end
    rst_n = 1'b0;
    tick(1'b1, 16'd321, 1'b1);
    total++; if (level !== 3'd0 || sound !== 16'h0 || dbg_gain !== 8'd0) begin bad++; $display("FAIL mid_reset got=%0d/%0d/%0d want=0/0/0", level, sound, dbg_gain); end
    total++; if (underrun !== 1'b0 || overrun !== 1'b0 || muted !== 1'b0) begin bad++; $display("FAIL mid_reset_pulses got=%b%b%b want=000", underrun, overrun, muted); end
    rst_n = 1'b1;
    tick(1'b0, 16'h0, 1'b1);
    total++; if (underrun !== 1'b1 || sound !== 16'h0) begin bad++; $display("FAIL mid_after got=%b/%0d want=1/0", underrun, sound); end
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_unity_and_sat();
    test_overrun();
    test_underrun();
    test_mute();
    test_reset_mid_ramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
